// File: rtl/instr_encoder_loader_if.sv
// Field-level instruction request channel with a valid/ready handshake.
// master drives the request fields and valid_i; slave returns ready_o.
interface instr_encoder_loader_if;
    logic        valid_i;
    logic        ready_o;
    logic        last_i;
    logic [2:0]  op_class_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic        funct7b5_i;
    logic [31:0] imm_i;

    modport master (
        output valid_i, last_i, op_class_i, rd_i, rs1_i, rs2_i,
        output funct3_i, funct7b5_i, imm_i,
        input  ready_o
    );

    modport slave (
        input  valid_i, last_i, op_class_i, rd_i, rs1_i, rs2_i,
        input  funct3_i, funct7b5_i, imm_i,
        output ready_o
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and instruction-memory writer.
// Ports: clk, rst (async high); start_i/base_addr_i open a load sequence;
// req (slave) carries field-level requests; mem_we_o/mem_addr_o/mem_wdata_o
// write encoded words at consecutive word addresses; count_o, done_o,
// error_o and err_code_o report sequence progress and the first error.
module instr_encoder_loader #(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 256,
    localparam int CW       = $clog2(MAX_WORDS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    instr_encoder_loader_if.slave req,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [CW-1:0]         count_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [1:0]            err_code_o
);

    localparam logic [2:0] C_LOAD   = 3'd0;
    localparam logic [2:0] C_STORE  = 3'd1;
    localparam logic [2:0] C_REG    = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3;
    localparam logic [2:0] C_IMM    = 3'd4;
    localparam logic [2:0] C_JAL    = 3'd5;
    localparam logic [2:0] C_JALR   = 3'd6;
    localparam logic [2:0] C_LUI    = 3'd7;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] E_RANGE = 2'b01;
    localparam logic [1:0] E_MIS   = 2'b10;
    localparam logic [1:0] E_OVF   = 2'b11;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_ENC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [2:0]        f3_q;
    logic              f7_q;
    logic [31:0]       imm_q;
    logic              last_q;
    logic [CW-1:0]     count_q;
    logic              err_q;
    logic [1:0]        code_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       word;
    logic              rng_bad;
    logic              mis_bad;
    logic              chk_fail;
    logic              ovf;
    logic              fits_i;
    logic              fits_b;
    logic              fits_j;
    logic              is_shift;
    logic [ADDR_W-1:0] addr_next;

    // Signed fit tests: upper bits must be a pure sign extension.
    assign fits_i   = (&imm_q[31:11]) | ~(|imm_q[31:11]);
    assign fits_b   = (&imm_q[31:12]) | ~(|imm_q[31:12]);
    assign fits_j   = (&imm_q[31:20]) | ~(|imm_q[31:20]);
    assign is_shift = (f3_q == 3'b001) || (f3_q == 3'b101);

    always_comb begin
        word    = '0;
        rng_bad = 1'b0;
        mis_bad = 1'b0;
        unique case (op_q)
            C_LOAD: begin
                word    = {imm_q[11:0], rs1_q, f3_q, rd_q, OPC_LOAD};
                rng_bad = ~fits_i;
            end
            C_STORE: begin
                word    = {imm_q[11:5], rs2_q, rs1_q, f3_q,
                           imm_q[4:0], OPC_STORE};
                rng_bad = ~fits_i;
            end
            C_REG: begin
                word = {1'b0, f7_q, 5'b0, rs2_q, rs1_q, f3_q,
                        rd_q, OPC_REG};
            end
            C_BRANCH: begin
                word    = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                           imm_q[4:1], imm_q[11], OPC_BRANCH};
                rng_bad = ~fits_b;
                mis_bad = imm_q[0];
            end
            C_IMM: begin
                if (is_shift) begin
                    word    = {1'b0, f7_q, 5'b0, imm_q[4:0], rs1_q,
                               f3_q, rd_q, OPC_IMM};
                    rng_bad = |imm_q[31:5];
                end else begin
                    word    = {imm_q[11:0], rs1_q, f3_q, rd_q, OPC_IMM};
                    rng_bad = ~fits_i;
                end
            end
            C_JAL: begin
                word    = {imm_q[20], imm_q[10:1], imm_q[11],
                           imm_q[19:12], rd_q, OPC_JAL};
                rng_bad = ~fits_j;
                mis_bad = imm_q[0];
            end
            C_JALR: begin
                word    = {imm_q[11:0], rs1_q, 3'b000, rd_q, OPC_JALR};
                rng_bad = ~fits_i;
            end
            C_LUI: begin
                word    = {imm_q[31:12], rd_q, OPC_LUI};
                rng_bad = |imm_q[11:0];
            end
        endcase
    end

    assign chk_fail  = rng_bad | mis_bad;
    assign ovf       = (count_q == MAX_CNT);
    assign addr_next = base_q + (ADDR_W'(count_q) << 2);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_READY;
            S_READY: if (req.valid_i) state_d = S_ENC;
            S_ENC: begin
                if (chk_fail) begin
                    state_d = last_q ? S_DONE : S_READY;
                end else if (ovf) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = last_q ? S_DONE : S_READY;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode the async-reset state, so a reset during WRITE
    // drops mem_we_o without waiting for a clock edge.
    assign req.ready_o = (state_q == S_READY);
    assign mem_we_o    = (state_q == S_WRITE);
    assign done_o      = (state_q == S_DONE);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign count_o     = count_q;
    assign error_o     = err_q;
    assign err_code_o  = code_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            f3_q    <= '0;
            f7_q    <= 1'b0;
            imm_q   <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        base_q  <= {base_addr_i[ADDR_W-1:2], 2'b00};
                        count_q <= '0;
                        err_q   <= 1'b0;
                        code_q  <= '0;
                    end
                end
                S_READY: begin
                    if (req.valid_i) begin
                        op_q   <= req.op_class_i;
                        rd_q   <= req.rd_i;
                        rs1_q  <= req.rs1_i;
                        rs2_q  <= req.rs2_i;
                        f3_q   <= req.funct3_i;
                        f7_q   <= req.funct7b5_i;
                        imm_q  <= req.imm_i;
                        last_q <= req.last_i;
                    end
                end
                S_ENC: begin
                    if (chk_fail) begin
                        err_q <= 1'b1;
                        if (code_q == 2'b00) begin
                            code_q <= mis_bad ? E_MIS : E_RANGE;
                        end
                    end else if (ovf) begin
                        err_q <= 1'b1;
                        if (code_q == 2'b00) begin
                            code_q <= E_OVF;
                        end
                    end else begin
                        addr_q  <= addr_next;
                        wdata_q <= word;
                    end
                end
                S_WRITE: count_q <= count_q + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
